commit_walk_eng: RTL

//  VR commit engine; processes one commit message end to end.

---
 rtl/commit_walk_if.sv | 76 +++++++
 rtl/commit_walk_eng.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/commit_walk_if.sv
// Handshake bundle between the commit walk engine and the dispatch stage,
// vr_state memory and log-header memory.
interface commit_walk_if #(
  parameter int NOC_DATA_W      = 512,
  parameter int VIEW_W          = 64,
  parameter int OPNUM_W         = 64,
  parameter int LOG_HDR_DEPTH   = 64,
  parameter int LOG_HDR_DEPTH_W = $clog2(LOG_HDR_DEPTH),
  parameter int ST_W            = 2
);
  logic                       msg_val;
  logic                       msg_rdy;
  logic [NOC_DATA_W-1:0]      msg_data;

  logic                       st_rd_req_val;
  logic                       st_rd_req_rdy;
  logic                       st_rd_resp_val;
  logic [VIEW_W-1:0]          st_curr_view;
  logic [OPNUM_W-1:0]         st_last_commit;
  logic [OPNUM_W-1:0]         st_last_op;
  logic [OPNUM_W-1:0]         st_first_log_op;
  logic [LOG_HDR_DEPTH_W-1:0] st_log_head;

  logic                       st_wr_val;
  logic                       st_wr_rdy;
  logic [OPNUM_W-1:0]         st_wr_last_commit;

  logic                       log_rd_val;
  logic                       log_rd_rdy;
  logic [LOG_HDR_DEPTH_W-1:0] log_rd_addr;
  logic                       log_rd_resp_val;
  logic [OPNUM_W-1:0]         log_rd_op;
  logic [ST_W-1:0]            log_rd_state;

  logic                       log_wr_val;
  logic                       log_wr_rdy;
  logic [LOG_HDR_DEPTH_W-1:0] log_wr_addr;
  logic [ST_W-1:0]            log_wr_state;

  logic                       done_val;
  logic                       done_rdy;
  logic [1:0]                 done_status;
  logic [OPNUM_W-1:0]         done_cnt;

  modport master (
    input  msg_val, msg_data,
    output msg_rdy,
    output st_rd_req_val,
    input  st_rd_req_rdy, st_rd_resp_val, st_curr_view, st_last_commit,
    input  st_last_op, st_first_log_op, st_log_head,
    output st_wr_val, st_wr_last_commit,
    input  st_wr_rdy,
    output log_rd_val, log_rd_addr,
    input  log_rd_rdy, log_rd_resp_val, log_rd_op, log_rd_state,
    output log_wr_val, log_wr_addr, log_wr_state,
    input  log_wr_rdy,
    output done_val, done_status, done_cnt,
    input  done_rdy
  );

  modport slave (
    output msg_val, msg_data,
    input  msg_rdy,
    input  st_rd_req_val,
    output st_rd_req_rdy, st_rd_resp_val, st_curr_view, st_last_commit,
    output st_last_op, st_first_log_op, st_log_head,
    input  st_wr_val, st_wr_last_commit,
    output st_wr_rdy,
    input  log_rd_val, log_rd_addr,
    output log_rd_rdy, log_rd_resp_val, log_rd_op, log_rd_state,
    input  log_wr_val, log_wr_addr, log_wr_state,
    output log_wr_rdy,
    input  done_val, done_status, done_cnt,
    output done_rdy
  );
endinterface

// File: rtl/commit_walk_eng.sv
// VR commit engine: validates a commit against vr_state, marks every log header
// from last_commit+1 up to the commit opnum COMMITTED, then writes last_commit back.
module commit_walk_eng #(
  parameter int NOC_DATA_W      = 512,
  parameter int VIEW_W          = 64,
  parameter int OPNUM_W         = 64,
  parameter int LOG_HDR_DEPTH   = 64,
  parameter int LOG_HDR_DEPTH_W = $clog2(LOG_HDR_DEPTH),
  parameter int ST_W            = 2,
  parameter logic [ST_W-1:0] ST_COMMITTED = ST_W'(2)
) (
  input  logic           clk,
  input  logic           rst_n,
  commit_walk_if.master  bus
);
  localparam int AW = LOG_HDR_DEPTH_W;
  localparam logic [AW+1:0] DEPTH_X   = (AW+2)'(LOG_HDR_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(LOG_HDR_DEPTH - 1);
  localparam logic [1:0] STAT_OK       = 2'd0;
  localparam logic [1:0] STAT_REJECT   = 2'd1;
  localparam logic [1:0] STAT_MISMATCH = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_ST_RD, S_ST_WAIT, S_CHECK, S_LOG_RD, S_LOG_WAIT, S_LOG_WR, S_ST_WR, S_RESP
  } state_t;

  state_t               state;
  logic                 msg_rdy_q, st_rd_req_val_q, st_wr_val_q;
  logic                 log_rd_val_q, log_wr_val_q, done_val_q;
  logic [1:0]           status_q;
  logic [OPNUM_W-1:0]   cnt_q;
  logic [VIEW_W-1:0]    view_q, curr_view_q;
  logic [OPNUM_W-1:0]   opnum_q, last_commit_q, last_op_q, first_log_op_q, cur_op_q;
  logic [AW-1:0]        log_head_q, addr_q;

  // Physical slot of last_commit+1: offset from the log head, one conditional wrap.
  logic [OPNUM_W-1:0]   first_op, op_off;
  logic [AW:0]          off_t;
  logic [AW+1:0]        slot_sum, slot_mod;
  logic                 commit_ok;

  assign first_op  = last_commit_q + OPNUM_W'(1);
  assign op_off    = first_op - first_log_op_q;
  assign off_t     = op_off[AW:0];
  assign slot_sum  = {2'b00, log_head_q} + {1'b0, off_t};
  assign slot_mod  = (slot_sum >= DEPTH_X) ? slot_sum - DEPTH_X : slot_sum;
  assign commit_ok = (view_q == curr_view_q) && (opnum_q > last_commit_q) &&
                     (opnum_q <= last_op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      msg_rdy_q       <= 1'b0;
      st_rd_req_val_q <= 1'b0;
      st_wr_val_q     <= 1'b0;
      log_rd_val_q    <= 1'b0;
      log_wr_val_q    <= 1'b0;
      done_val_q      <= 1'b0;
      status_q        <= '0;
      cnt_q           <= '0;
      view_q          <= '0;
      curr_view_q     <= '0;
      opnum_q         <= '0;
      last_commit_q   <= '0;
      last_op_q       <= '0;
      first_log_op_q  <= '0;
      cur_op_q        <= '0;
      log_head_q      <= '0;
      addr_q          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.msg_val && msg_rdy_q) begin
            view_q          <= bus.msg_data[NOC_DATA_W-1 -: VIEW_W];
            opnum_q         <= bus.msg_data[NOC_DATA_W-VIEW_W-1 -: OPNUM_W];
            cnt_q           <= '0;
            msg_rdy_q       <= 1'b0;
            st_rd_req_val_q <= 1'b1;
            state           <= S_ST_RD;
          end else begin
            msg_rdy_q <= 1'b1;
          end
        end
        S_ST_RD: if (bus.st_rd_req_rdy) begin
          st_rd_req_val_q <= 1'b0;
          state           <= S_ST_WAIT;
        end
        S_ST_WAIT: if (bus.st_rd_resp_val) begin
          curr_view_q    <= bus.st_curr_view;
          last_commit_q  <= bus.st_last_commit;
          last_op_q      <= bus.st_last_op;
          first_log_op_q <= bus.st_first_log_op;
          log_head_q     <= bus.st_log_head;
          state          <= S_CHECK;
        end
        S_CHECK: begin
          if (commit_ok) begin
            cur_op_q     <= first_op;
            addr_q       <= slot_mod[AW-1:0];
            log_rd_val_q <= 1'b1;
            state        <= S_LOG_RD;
          end else begin
            status_q   <= STAT_REJECT;
            done_val_q <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_LOG_RD: if (bus.log_rd_rdy) begin
          log_rd_val_q <= 1'b0;
          state        <= S_LOG_WAIT;
        end
        S_LOG_WAIT: if (bus.log_rd_resp_val) begin
          // A header holding a different op means the log is not what vr_state claims.
          if (bus.log_rd_op != cur_op_q) begin
            status_q   <= STAT_MISMATCH;
            done_val_q <= 1'b1;
            state      <= S_RESP;
          end else begin
            log_wr_val_q <= 1'b1;
            state        <= S_LOG_WR;
          end
        end
        S_LOG_WR: if (bus.log_wr_rdy) begin
          log_wr_val_q <= 1'b0;
          cnt_q        <= cnt_q + OPNUM_W'(1);
          if (cur_op_q == opnum_q) begin
            st_wr_val_q <= 1'b1;
            state       <= S_ST_WR;
          end else begin
            cur_op_q     <= cur_op_q + OPNUM_W'(1);
            addr_q       <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
            log_rd_val_q <= 1'b1;
            state        <= S_LOG_RD;
          end
        end
        S_ST_WR: if (bus.st_wr_rdy) begin
          st_wr_val_q <= 1'b0;
          status_q    <= STAT_OK;
          done_val_q  <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: if (bus.done_rdy) begin
          done_val_q <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.msg_rdy           = msg_rdy_q;
  assign bus.st_rd_req_val     = st_rd_req_val_q;
  assign bus.st_wr_val         = st_wr_val_q;
  assign bus.st_wr_last_commit = st_wr_val_q ? opnum_q : '0;
  assign bus.log_rd_val        = log_rd_val_q;
  assign bus.log_rd_addr       = addr_q;
  assign bus.log_wr_val        = log_wr_val_q;
  assign bus.log_wr_addr       = addr_q;
  assign bus.log_wr_state      = log_wr_val_q ? ST_COMMITTED : '0;
  assign bus.done_val          = done_val_q;
  assign bus.done_status       = status_q;
  assign bus.done_cnt          = cnt_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.msg_data[NOC_DATA_W-VIEW_W-OPNUM_W-1:0], bus.log_rd_state,
                       op_off[OPNUM_W-1:AW+1], slot_mod[AW+1:AW]};
endmodule
